// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: EXE->WB memory stage with req/ack data-memory handshake,
// lane steering, load extension, misalignment and timeout reporting.
module mem_stage_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int REG_AW  = 5,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic              needs_wb,
   input  logic [REG_AW-1:0] rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              out_valid,
   output logic              wb_wen,
   output logic [REG_AW-1:0] wb_rd,
   output logic [31:0]       wb_data,
   output logic              err_misalign,
   output logic              err_timeout
);
   typedef enum logic {IDLE, REQ} state_t;
   localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
   state_t            state_q;
   logic [31:0]       cnt_q;
   logic [1:0]        off_q;
   logic [1:0]        size_q;
   logic              sign_q;
   logic              needs_wb_q;
   logic [REG_AW-1:0] rd_q;
   logic              is_mem;
   logic              misalign;
   logic              tmo;
   logic [3:0]        be_d;
   logic [31:0]       wdata_d;
   logic [31:0]       sh;
   logic [31:0]       load_d;
   assign in_ready = (state_q == IDLE);
   always_comb begin
      is_mem   = is_load | is_store;
      misalign = (size == 2'b11) | ((size == 2'b01) & addr[0]) | ((size == 2'b10) & (addr[1:0] != 2'b00));
      be_d     = (size == 2'b00) ? 4'b0001 << addr[1:0] : (size == 2'b01) ? 4'b0011 << addr[1:0] : 4'b1111;
      wdata_d  = (size == 2'b00) ? {4{wdata[7:0]}} : (size == 2'b01) ? {2{wdata[15:0]}} : wdata;
      sh       = mem_rdata >> {off_q, 3'b000};
      load_d   = (size_q == 2'b00) ? (sign_q ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]}) :
                 (size_q == 2'b01) ? (sign_q ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]}) : mem_rdata;
      tmo      = (TIMEOUT > 0) && (cnt_q == TMO_LAST);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         off_q        <= '0;
         size_q       <= '0;
         sign_q       <= 1'b0;
         needs_wb_q   <= 1'b0;
         rd_q         <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         out_valid    <= 1'b0;
         wb_wen       <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         wb_wen       <= 1'b0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
         if (state_q == IDLE) begin
            if (in_valid && !is_mem) begin
               out_valid <= 1'b1;
               wb_wen    <= needs_wb;
               wb_rd     <= rd;
               wb_data   <= wdata;
            end else if (in_valid && misalign) begin
               out_valid    <= 1'b1;
               err_misalign <= 1'b1;
               wb_rd        <= rd;
            end else if (in_valid) begin
               state_q    <= REQ;
               cnt_q      <= '0;
               off_q      <= addr[1:0];
               size_q     <= size;
               sign_q     <= sign_ext;
               needs_wb_q <= needs_wb;
               rd_q       <= rd;
               mem_req    <= 1'b1;
               mem_we     <= is_store;
               mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
               mem_be     <= be_d;
               mem_wdata  <= wdata_d;
            end
         end else if (mem_ack) begin
            // ack beats a coincident timeout
            state_q   <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b1;
            wb_wen    <= needs_wb_q & ~mem_we;
            wb_rd     <= rd_q;
            if (!mem_we) wb_data <= load_d;
         end else if (tmo) begin
            state_q     <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            out_valid   <= 1'b1;
            err_timeout <= 1'b1;
            wb_rd       <= rd_q;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end
   end
endmodule
